// File: rtl/bisr_pkg.sv
// Shared types and width helpers for the BISR faulty-PE allocation path.
package bisr_pkg;

  // Width of an index over n items; a single item still needs one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must reach n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned SYSTOLIC_SIZE_DEF = 8;
  localparam int unsigned DEPTH_DEF         = 8;
  localparam int unsigned ADDR_W            = addr_w(SYSTOLIC_SIZE_DEF);
  localparam int unsigned CNT_W             = cnt_w(SYSTOLIC_SIZE_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] row;
    logic              hit;
    logic [ADDR_W-1:0] faulty_row;
  } result_t;

endpackage

// File: rtl/bisr_load_buffer.sv
// Local buffer of faulty-PE records streamed from the eNVM reader,
// presented flattened for a single bulk write into the faulty-PE storage.
module bisr_load_buffer
  import bisr_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE = 8,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned ADDR_WIDTH    = 3,
  parameter int unsigned IDX_W         = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [SYSTOLIC_SIZE-1:0]      wr_pattern,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [IDX_W-1:0]              idx,
  output logic [DEPTH*SYSTOLIC_SIZE-1:0] patterns_flat,
  output logic [DEPTH*ADDR_WIDTH-1:0]   addrs_flat,
  output logic [DEPTH-1:0]              valid_mask
);

  logic [SYSTOLIC_SIZE-1:0] pat  [DEPTH];
  logic [ADDR_WIDTH-1:0]    addr [DEPTH];

  // Slot storage; an all-zero pattern is a null entry and leaves its valid bit clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pat[i]  <= '0;
        addr[i] <= '0;
      end
      valid_mask <= '0;
      idx        <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pat[i]  <= '0;
        addr[i] <= '0;
      end
      valid_mask <= '0;
      idx        <= '0;
    end else if (wr_en) begin
      pat[idx]        <= wr_pattern;
      addr[idx]       <= wr_addr;
      valid_mask[idx] <= |wr_pattern;
      idx             <= idx + 1'b1;
    end
  end

  // Flatten slots for the storage bulk-write port.
  always_comb begin
    patterns_flat = '0;
    addrs_flat    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      patterns_flat[i*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] = pat[i];
      addrs_flat[i*ADDR_WIDTH +: ADDR_WIDTH]          = addr[i];
    end
  end

endmodule

// File: rtl/bisr_alloc_ctrl.sv
// Sequencer for BISR faulty-PE allocation: load records, commit them to the
// storage, then issue weight rows one at a time and collect match results.
module bisr_alloc_ctrl
  import bisr_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE        = SYSTOLIC_SIZE_DEF,
  parameter int unsigned FAULTY_STORAGE_DEPTH = DEPTH_DEF,
  parameter int unsigned ADDR_WIDTH           = addr_w(SYSTOLIC_SIZE),
  parameter int unsigned CNT_WIDTH            = cnt_w(SYSTOLIC_SIZE)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic                                         nvm_valid,
  output logic                                         nvm_ready,
  input  logic [SYSTOLIC_SIZE-1:0]                     nvm_pattern,
  input  logic [ADDR_WIDTH-1:0]                        nvm_row_addr,
  input  logic                                         nvm_last,
  input  logic                                         wt_valid,
  output logic                                         wt_ready,
  input  logic [SYSTOLIC_SIZE-1:0]                     wt_zero_flags,
  output logic                                         st_wr_en,
  output logic [FAULTY_STORAGE_DEPTH*SYSTOLIC_SIZE-1:0] st_patterns_flat,
  output logic [FAULTY_STORAGE_DEPTH*ADDR_WIDTH-1:0]   st_row_addrs_flat,
  output logic [FAULTY_STORAGE_DEPTH-1:0]              st_valid_mask,
  output logic [SYSTOLIC_SIZE-1:0]                     st_zero_flags,
  output logic                                         st_weight_valid,
  output logic [ADDR_WIDTH-1:0]                        st_row_addr,
  input  logic                                         st_match_success,
  input  logic                                         st_match_failed,
  input  logic [ADDR_WIDTH-1:0]                        st_faulty_row_addr,
  input  logic                                         st_all_faulty_matched,
  output logic                                         res_valid,
  output logic [ADDR_WIDTH-1:0]                        res_row,
  output logic                                         res_hit,
  output logic [ADDR_WIDTH-1:0]                        res_faulty_row,
  output logic                                         done,
  output logic                                         pass,
  output logic [CNT_WIDTH-1:0]                         fail_count
);

  localparam int unsigned IDX_W = addr_w(FAULTY_STORAGE_DEPTH);

  state_e                state_q, state_d;
  logic                  clear;
  logic                  buf_wr;
  logic [IDX_W-1:0]      load_idx;
  logic                  buf_full;
  logic                  last_row;
  logic [ADDR_WIDTH-1:0] row_q;
  logic [CNT_WIDTH-1:0]  fail_q;
  logic                  done_q, pass_q, res_valid_q;
  result_t               res_q;

  assign buf_wr   = nvm_valid && nvm_ready;
  assign buf_full = (load_idx == IDX_W'(FAULTY_STORAGE_DEPTH - 1));
  assign last_row = (row_q == ADDR_WIDTH'(SYSTOLIC_SIZE - 1));

  bisr_load_buffer #(
    .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
    .DEPTH         (FAULTY_STORAGE_DEPTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .IDX_W         (IDX_W)
  ) u_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .wr_en         (buf_wr),
    .wr_pattern    (nvm_pattern),
    .wr_addr       (nvm_row_addr),
    .idx           (load_idx),
    .patterns_flat (st_patterns_flat),
    .addrs_flat    (st_row_addrs_flat),
    .valid_mask    (st_valid_mask)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    nvm_ready = 1'b0;
    wt_ready  = 1'b0;
    st_wr_en  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          clear   = 1'b1;
        end
      end
      S_LOAD: begin
        nvm_ready = 1'b1;
        if (nvm_valid && (nvm_last || buf_full)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        st_wr_en = 1'b1;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        // All faults already matched wins over a pending weight row.
        if (st_all_faulty_matched) begin
          state_d = S_DONE;
        end else begin
          wt_ready = 1'b1;
          if (wt_valid) state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = last_row ? S_DONE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  assign st_weight_valid = wt_valid && wt_ready;
  assign st_zero_flags   = st_weight_valid ? wt_zero_flags : '0;
  assign st_row_addr     = row_q;

  // Row index, fail counter and completion status for the current run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      fail_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (clear) begin
      row_q  <= '0;
      fail_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      if (state_q == S_WAIT && !last_row) row_q <= row_q + 1'b1;
      if (state_q == S_WAIT && st_match_failed && fail_q != '1) fail_q <= fail_q + 1'b1;
      if (state_d == S_DONE && state_q != S_DONE) begin
        done_q <= 1'b1;
        pass_q <= st_all_faulty_matched;
      end
    end
  end

  // Capture the storage result for the mapping table, one strobe per row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      res_valid_q <= (state_q == S_WAIT);
      if (state_q == S_WAIT) begin
        res_q.row        <= row_q;
        res_q.hit        <= st_match_success;
        res_q.faulty_row <= st_match_success ? st_faulty_row_addr : '0;
      end
    end
  end

  assign res_valid      = res_valid_q;
  assign res_row        = res_q.row;
  assign res_hit        = res_q.hit;
  assign res_faulty_row = res_q.faulty_row;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_q;

endmodule

// File: tb/tb_bisr_alloc_ctrl.sv
// Directed bench for bisr_alloc_ctrl with a behavioural faulty-PE storage.
module tb_bisr_alloc_ctrl;

  localparam int SS = 8;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk, rst_n, start;
  logic          nvm_valid, nvm_ready, nvm_last;
  logic [SS-1:0] nvm_pattern;
  logic [AW-1:0] nvm_row_addr;
  logic          wt_valid, wt_ready;
  logic [SS-1:0] wt_zero_flags;
  logic          st_wr_en;
  logic [D*SS-1:0] st_patterns_flat;
  logic [D*AW-1:0] st_row_addrs_flat;
  logic [D-1:0]  st_valid_mask;
  logic [SS-1:0] st_zero_flags;
  logic          st_weight_valid;
  logic [AW-1:0] st_row_addr;
  logic          st_match_success, st_match_failed;
  logic [AW-1:0] st_faulty_row_addr;
  logic          st_all_faulty_matched;
  logic          res_valid, res_hit, done, pass;
  logic [AW-1:0] res_row, res_faulty_row;
  logic [CW-1:0] fail_count;

  int n_cmp = 0;
  int n_bad = 0;

  bisr_alloc_ctrl #(
    .SYSTOLIC_SIZE(SS), .FAULTY_STORAGE_DEPTH(D), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .nvm_valid(nvm_valid), .nvm_ready(nvm_ready), .nvm_pattern(nvm_pattern),
    .nvm_row_addr(nvm_row_addr), .nvm_last(nvm_last),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_zero_flags(wt_zero_flags),
    .st_wr_en(st_wr_en), .st_patterns_flat(st_patterns_flat),
    .st_row_addrs_flat(st_row_addrs_flat), .st_valid_mask(st_valid_mask),
    .st_zero_flags(st_zero_flags), .st_weight_valid(st_weight_valid),
    .st_row_addr(st_row_addr), .st_match_success(st_match_success),
    .st_match_failed(st_match_failed), .st_faulty_row_addr(st_faulty_row_addr),
    .st_all_faulty_matched(st_all_faulty_matched),
    .res_valid(res_valid), .res_row(res_row), .res_hit(res_hit),
    .res_faulty_row(res_faulty_row), .done(done), .pass(pass), .fail_count(fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage model: a slot matches when every faulty PE sees a zero weight.
  logic [SS-1:0] m_pat  [D];
  logic [AW-1:0] m_addr [D];
  logic [D-1:0]  m_mask, m_matched;

  function automatic int find_slot(input logic [SS-1:0] zf);
    for (int k = 0; k < D; k++)
      if (m_mask[k] && !m_matched[k] && ((m_pat[k] & ~zf) == '0)) return k;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mask <= '0; m_matched <= '0;
      st_match_success <= 1'b0; st_match_failed <= 1'b0; st_faulty_row_addr <= '0;
      for (int k = 0; k < D; k++) begin m_pat[k] <= '0; m_addr[k] <= '0; end
    end else begin
      st_match_success <= 1'b0; st_match_failed <= 1'b0; st_faulty_row_addr <= '0;
      if (st_wr_en) begin
        for (int k = 0; k < D; k++) begin
          m_pat[k]  <= st_patterns_flat[k*SS +: SS];
          m_addr[k] <= st_row_addrs_flat[k*AW +: AW];
        end
        m_mask <= st_valid_mask; m_matched <= '0;
      end
      if (st_weight_valid) begin
        if (find_slot(st_zero_flags) >= 0) begin
          st_match_success   <= 1'b1;
          st_faulty_row_addr <= m_addr[find_slot(st_zero_flags)];
          m_matched[find_slot(st_zero_flags)] <= 1'b1;
        end else begin
          st_match_failed <= 1'b1;
        end
      end
    end
  end
  assign st_all_faulty_matched = ((m_mask & ~m_matched) == '0);

  // Result log and strobe counters, sampled mid-cycle.
  logic [2*AW:0] res_log [$];
  int wv_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (rst_n && res_valid) res_log.push_back({res_row, res_hit, res_faulty_row});
    if (st_weight_valid) wv_cnt <= wv_cnt + 1;
    if (st_wr_en) wr_cnt <= wr_cnt + 1;
  end

  logic [SS-1:0] rp [16];
  logic [AW-1:0] ra [16];
  logic [SS-1:0] flags [SS];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_start;
    start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic load_list(input int n, input bit use_last, output int acc);
    int tmo;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      nvm_valid = 1'b1; nvm_pattern = rp[i]; nvm_row_addr = ra[i];
      nvm_last = use_last && (i == n - 1);
      tmo = 0;
      while (!nvm_ready && tmo < 3) begin tick; tmo++; end
      if (!nvm_ready) break;
      tick; acc++;
    end
    nvm_valid = 1'b0; nvm_last = 1'b0; nvm_pattern = '0; nvm_row_addr = '0;
  endtask

  task automatic run_rows(input logic [SS-1:0] gaps, output int issued);
    int tmo;
    issued = 0; tmo = 0;
    for (int r = 0; r < SS; r++) begin
      if (done) break;
      if (gaps[r]) begin wt_valid = 1'b0; tick; tick; end
      wt_valid = 1'b1; wt_zero_flags = flags[r];
      while (!wt_ready && !done && tmo < 40) begin tick; tmo++; end
      if (!wt_ready) break;
      tick; issued++;
    end
    wt_valid = 1'b0; wt_zero_flags = '0;
    while (!done && tmo < 40) begin tick; tmo++; end
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; nvm_valid = 0; nvm_last = 0; nvm_pattern = '0;
    nvm_row_addr = '0; wt_valid = 0; wt_zero_flags = '0;
    tick; tick;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL rst_pass got=%b exp=0", pass); end
    n_cmp++; if (fail_count !== '0) begin n_bad++; $display("FAIL rst_fail_count got=%0d exp=0", fail_count); end
    n_cmp++; if ({nvm_ready, wt_ready, st_wr_en, st_weight_valid, res_valid} !== 5'b0) begin n_bad++; $display("FAIL rst_strobes got=%b exp=00000", {nvm_ready, wt_ready, st_wr_en, st_weight_valid, res_valid}); end
    n_cmp++; if (st_valid_mask !== '0 || st_patterns_flat !== '0) begin n_bad++; $display("FAIL rst_buffer got=%h/%h exp=0", st_valid_mask, st_patterns_flat); end
    rst_n = 1'b1; tick;
    nvm_valid = 1'b1; tick;
    n_cmp++; if (nvm_ready !== 1'b0) begin n_bad++; $display("FAIL idle_no_ready got=%b exp=0", nvm_ready); end
    nvm_valid = 1'b0;
  endtask

  task automatic test_two_faults;
    int acc, iss, rb, wb, wrb;
    rp[0] = 8'h01; ra[0] = 3'd2; rp[1] = 8'h80; ra[1] = 3'd5;
    flags[0] = 8'h01; flags[1] = 8'h80;
    for (int k = 2; k < SS; k++) flags[k] = 8'h00;
    rb = res_log.size(); wb = wv_cnt; wrb = wr_cnt;
    do_start;
    load_list(2, 1'b1, acc);
    n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL two_accepted got=%0d exp=2", acc); end
    n_cmp++; if (st_wr_en !== 1'b1) begin n_bad++; $display("FAIL two_commit got=%b exp=1", st_wr_en); end
    n_cmp++; if (st_valid_mask !== 8'h03) begin n_bad++; $display("FAIL two_mask got=%h exp=03", st_valid_mask); end
    n_cmp++; if (st_row_addrs_flat[5:0] !== 6'b101_010) begin n_bad++; $display("FAIL two_addrs got=%b exp=101010", st_row_addrs_flat[5:0]); end
    run_rows('0, iss);
    n_cmp++; if (iss !== 2) begin n_bad++; $display("FAIL two_issued got=%0d exp=2", iss); end
    n_cmp++; if (res_log.size() - rb !== 2) begin n_bad++; $display("FAIL two_res_count got=%0d exp=2", res_log.size() - rb); end
    if (res_log.size() - rb >= 2) begin
      n_cmp++; if (res_log[rb] !== {3'd0, 1'b1, 3'd2}) begin n_bad++; $display("FAIL two_res0 got=%b exp=0001010", res_log[rb]); end
      n_cmp++; if (res_log[rb+1] !== {3'd1, 1'b1, 3'd5}) begin n_bad++; $display("FAIL two_res1 got=%b exp=0011101", res_log[rb+1]); end
    end
    n_cmp++; if ({done, pass} !== 2'b11) begin n_bad++; $display("FAIL two_done_pass got=%b exp=11", {done, pass}); end
    n_cmp++; if (fail_count !== 4'd0) begin n_bad++; $display("FAIL two_fail_count got=%0d exp=0", fail_count); end
    n_cmp++; if (wv_cnt - wb !== 2) begin n_bad++; $display("FAIL two_weight_valid got=%0d exp=2", wv_cnt - wb); end
    n_cmp++; if (wr_cnt - wrb !== 1) begin n_bad++; $display("FAIL two_wr_pulses got=%0d exp=1", wr_cnt - wrb); end
  endtask

  task automatic test_empty_list;
    int acc, wb;
    rp[0] = 8'h00; ra[0] = 3'd0;
    wb = wv_cnt;
    do_start;
    load_list(1, 1'b1, acc);
    n_cmp++; if (st_wr_en !== 1'b1) begin n_bad++; $display("FAIL empty_commit got=%b exp=1", st_wr_en); end
    n_cmp++; if (st_valid_mask !== 8'h00) begin n_bad++; $display("FAIL empty_mask got=%h exp=00", st_valid_mask); end
    tick;
    n_cmp++; if ({wt_ready, done} !== 2'b00) begin n_bad++; $display("FAIL empty_issue got=%b exp=00", {wt_ready, done}); end
    tick;
    n_cmp++; if ({done, pass} !== 2'b11) begin n_bad++; $display("FAIL empty_done_pass got=%b exp=11", {done, pass}); end
    n_cmp++; if (wv_cnt - wb !== 0) begin n_bad++; $display("FAIL empty_no_weight got=%0d exp=0", wv_cnt - wb); end
  endtask

  task automatic test_conflict;
    int acc, iss, rb;
    rp[0] = 8'h0F; ra[0] = 3'd3;
    for (int k = 0; k < SS; k++) flags[k] = 8'h00;
    rb = res_log.size();
    do_start;
    load_list(1, 1'b1, acc);
    run_rows('0, iss);
    n_cmp++; if (res_log.size() - rb !== 8) begin n_bad++; $display("FAIL conf_res_count got=%0d exp=8", res_log.size() - rb); end
    for (int k = 0; k < SS && rb + k < res_log.size(); k++) begin
      n_cmp++; if (res_log[rb+k] !== {3'(k), 1'b0, 3'd0}) begin n_bad++; $display("FAIL conf_res%0d got=%b exp=%b", k, res_log[rb+k], {3'(k), 1'b0, 3'd0}); end
    end
    n_cmp++; if (fail_count !== 4'd8) begin n_bad++; $display("FAIL conf_fail_count got=%0d exp=8", fail_count); end
    n_cmp++; if ({done, pass} !== 2'b10) begin n_bad++; $display("FAIL conf_done_pass got=%b exp=10", {done, pass}); end
  endtask

  task automatic test_overflow;
    int acc, iss, wrb;
    for (int k = 0; k < 10; k++) begin rp[k] = 8'(k + 1); ra[k] = 3'(k); end
    for (int k = 0; k < SS; k++) flags[k] = 8'hFF;
    wrb = wr_cnt;
    do_start;
    load_list(10, 1'b0, acc);
    n_cmp++; if (acc !== 8) begin n_bad++; $display("FAIL ovf_accepted got=%0d exp=8", acc); end
    n_cmp++; if (nvm_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready got=%b exp=0", nvm_ready); end
    n_cmp++; if (wr_cnt - wrb !== 1) begin n_bad++; $display("FAIL ovf_wr_pulses got=%0d exp=1", wr_cnt - wrb); end
    n_cmp++; if (st_valid_mask !== 8'hFF) begin n_bad++; $display("FAIL ovf_mask got=%h exp=ff", st_valid_mask); end
    n_cmp++; if (st_patterns_flat[63:56] !== 8'h08) begin n_bad++; $display("FAIL ovf_slot7 got=%h exp=08", st_patterns_flat[63:56]); end
    run_rows('0, iss);
    n_cmp++; if (iss !== 8) begin n_bad++; $display("FAIL ovf_issued got=%0d exp=8", iss); end
    n_cmp++; if ({done, pass, fail_count} !== {2'b11, 4'd0}) begin n_bad++; $display("FAIL ovf_status got=%b exp=110000", {done, pass, fail_count}); end
  endtask

  task automatic test_back_to_back;
    int acc, iss, rb, wb;
    rp[0] = 8'h01; ra[0] = 3'd0;
    for (int k = 0; k < SS; k++) flags[k] = 8'h00;
    rb = res_log.size(); wb = wv_cnt;
    do_start;
    load_list(1, 1'b1, acc);
    run_rows(8'b1010_0101, iss);
    n_cmp++; if (iss !== 8) begin n_bad++; $display("FAIL bp_issued got=%0d exp=8", iss); end
    n_cmp++; if (wv_cnt - wb !== 8) begin n_bad++; $display("FAIL bp_weight_valid got=%0d exp=8", wv_cnt - wb); end
    for (int k = 0; k < SS && rb + k < res_log.size(); k++) begin
      n_cmp++; if (res_log[rb+k][6:4] !== 3'(k)) begin n_bad++; $display("FAIL bp_row%0d got=%0d exp=%0d", k, res_log[rb+k][6:4], k); end
    end
    n_cmp++; if ({done, pass, fail_count} !== {2'b10, 4'd8}) begin n_bad++; $display("FAIL bp_status got=%b exp=101000", {done, pass, fail_count}); end
  endtask

  task automatic test_reset_in_wait;
    int acc, tmo;
    rp[0] = 8'h0F; ra[0] = 3'd3;
    do_start;
    load_list(1, 1'b1, acc);
    tick;
    for (int k = 0; k < 3; k++) begin
      wt_valid = 1'b1; wt_zero_flags = 8'h00; tmo = 0;
      while (!wt_ready && tmo < 10) begin tick; tmo++; end
      tick;
      wt_valid = 1'b0;
      if (k < 2) tick;
    end
    n_cmp++; if (fail_count !== 4'd2) begin n_bad++; $display("FAIL rw_pre_fail_count got=%0d exp=2", fail_count); end
    rst_n = 1'b0; #1;
    n_cmp++; if ({done, pass, fail_count} !== 6'b0) begin n_bad++; $display("FAIL rw_status got=%b exp=000000", {done, pass, fail_count}); end
    n_cmp++; if ({nvm_ready, wt_ready, res_valid, st_row_addr} !== 6'b0) begin n_bad++; $display("FAIL rw_outputs got=%b exp=000000", {nvm_ready, wt_ready, res_valid, st_row_addr}); end
    n_cmp++; if (st_valid_mask !== '0) begin n_bad++; $display("FAIL rw_mask got=%h exp=00", st_valid_mask); end
    tick; rst_n = 1'b1; tick;
    n_cmp++; if (nvm_ready !== 1'b0) begin n_bad++; $display("FAIL rw_idle got=%b exp=0", nvm_ready); end
    test_two_faults;
  endtask

  initial begin
    test_reset;
    test_two_faults;
    test_empty_list;
    test_conflict;
    test_overflow;
    test_back_to_back;
    test_reset_in_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
